// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset vector, fetch entry bundle.
package cpu_pkg;

  localparam int          XLEN_D     = 32;
  localparam logic [31:0] RESET_PC_D = 32'h0000_0000;
  localparam int          PC_INC     = 4;

  typedef struct packed {
    logic [XLEN_D-1:0] pc;
    logic [XLEN_D-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; registered storage, combinational head read.
module sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC generation, imem handshake, redirect, buffered IF->ID.
// FETCH_BYPASS_EN forwards a response straight to ID when the queue is empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int             XLEN     = XLEN_D,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_D
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [2*XLEN-1:0] head;
  logic [CW-1:0]     f_count;
  logic              f_full, f_empty;
  logic              accept, byp, push, pop;

  assign imem_req  = rst & ~redirect & ~f_full;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req & imem_ready;

`ifdef FETCH_BYPASS_EN
  assign byp = accept & f_empty;
`else
  assign byp = 1'b0;
`endif

  // A bypassed entry taken by ID this cycle never enters storage.
  assign push = accept & ~(byp & id_ready);
  assign pop  = ~f_empty & id_ready & ~redirect;

  sync_fifo #(
    .W     (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({fetch_pc_q, imem_rdata}),
    .rdata (head),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  assign id_valid = ~f_empty | byp;
  assign id_pc    = byp ? fetch_pc_q : head[2*XLEN-1:XLEN];
  assign id_instr = byp ? imem_rdata : head[XLEN-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (accept)
      fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_pc_q <= RESET_PC;
    else      fetch_pc_q <= fetch_pc_d;
  end

  logic unused_count;
  assign unused_count = ^f_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an {pc, instr} scoreboard.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           ncmp = 0;
  int           nerr = 0;
  fetch_entry_t sb[$];
  logic [31:0]  mpc;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic step(input logic ir, input logic [31:0] rd,
                      input logic idr, input logic rdr,
                      input logic [31:0] rpc);
    logic ereq, eacc, ebyp;
    imem_ready  = ir;
    imem_rdata  = rd;
    id_ready    = idr;
    redirect    = rdr;
    redirect_pc = rpc;
    #2;
    ereq = !rdr && (sb.size() < DEPTH);
    eacc = ereq && ir;
    ebyp = BYP && eacc && (sb.size() == 0);
    chk("imem_req", 32'(imem_req), 32'(ereq));
    if (ereq) chk("imem_addr", imem_addr, mpc);
    chk("id_valid", 32'(id_valid), 32'(sb.size() != 0 || ebyp));
    if (ebyp) begin
      chk("byp_pc", id_pc, mpc);
      chk("byp_instr", id_instr, rd);
    end else if (sb.size() != 0) begin
      chk("id_pc", id_pc, sb[0].pc);
      chk("id_instr", id_instr, sb[0].instr);
    end
    @(posedge clk);
    #1;
    if (rdr) begin
      sb.delete();
      mpc = rpc & ~32'h3;
    end else begin
      if (sb.size() != 0 && idr) void'(sb.pop_front());
      if (eacc && !(ebyp && idr)) sb.push_back('{pc: mpc, instr: rd});
      if (eacc) mpc = mpc + 32'd4;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'h0);
    chk({tag, "_valid"}, 32'(id_valid), 32'h0);
    chk({tag, "_pc"},    id_pc,         32'h0);
    chk({tag, "_instr"}, id_instr,      32'h0);
  endtask

  initial begin
    rst         = 1'b0;
    imem_ready  = 1'b0;
    imem_rdata  = '0;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mpc         = 32'h0;
    #12;
    chk_reset_outs("rst0");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // fill with a 3-cycle stall at 0x8
    step(1, ins(32'h0), 0, 0, 0);
    step(1, ins(32'h4), 0, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    step(1, ins(32'h8), 0, 0, 0);
    step(1, ins(32'hC), 0, 0, 0);
    step(1, 32'h1111_1111, 0, 0, 0);
    chk("full_addr", imem_addr, 32'h10);

    // single pop from full, refill from 0x10
    step(1, 32'h2222_2222, 1, 0, 0);
    step(1, ins(32'h10), 0, 0, 0);
    step(1, 32'h3333_3333, 0, 0, 0);

    // drop to three entries, then redirect to 0x103
    step(0, 32'h0, 1, 0, 0);
    step(1, 32'hDEAD_BEEF, 1, 1, 32'h103);
    chk("redir_addr", imem_addr, 32'h100);
    step(1, ins(32'h100), 0, 0, 0);
    step(1, ins(32'h104), 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    // PC wrap at the top of the address space
    step(0, 32'h0, 0, 1, 32'hFFFF_FFFE);
    step(1, ins(32'hFFFF_FFFC), 1, 0, 0);
    step(1, ins(32'h0), 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    // async reset pulse during a stall
    step(1, ins(32'h8), 0, 0, 0);
    imem_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outs("rstp");
    #4;
    rst = 1'b1;
    sb.delete();
    mpc = 32'h0;
    @(posedge clk);
    #1;
    step(0, 32'h0, 0, 0, 0);

    // empty queue, response with ID ready (bypass or one-cycle fill)
    step(1, 32'h0050_0093, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(1, 32'h0010_0113, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the 5-stage pipelined CPU. It replaces the direct PC-register / IF-ID coupling.
- Owns the fetch PC and issues requests to instruction memory with a req/ready handshake. Buffers up to DEPTH fetched {pc, instr} pairs in a FIFO.
- Presents the FIFO head to ID with a valid/ready handshake. Honours a redirect (branch/jump flush) from the resolve stage.
- Tolerates instruction memory that stalls for any number of cycles.

Parameters:
XLEN, 32, width of PC and instruction words
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (low = reset)
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address; equals the fetch PC
imem_ready  in  1  memory accepts the request; imem_rdata valid in the same cycle
imem_rdata  in  XLEN  fetched instruction
id_valid  out  1  FIFO head valid
id_ready  in  1  ID accepts head (driven by the CPU as !pause)
id_pc  out  XLEN  head PC
id_instr  out  XLEN  head instruction
redirect  in  1  flush and restart fetch
redirect_pc  in  XLEN  restart address

Behaviour:
- Reset (rst low, async):
  - fetch_pc = RESET_PC; count = 0; rd_ptr = wr_ptr = 0; FIFO storage = 0.
  - imem_req = 0, id_valid = 0, id_pc = 0, id_instr = 0 while rst is low.
  - Reset asserted mid-transfer drops any in-flight request and all buffered entries.
- imem_req = rst & !redirect & (count < DEPTH). imem_addr = fetch_pc.
- Accept = imem_req & imem_ready. On accept:
  - push {fetch_pc, imem_rdata};
  - fetch_pc += 4 (mod 2^XLEN, wraps silently).
- Stall: fetch_pc holds while imem_req & !imem_ready, so imem_addr stays stable.
- Pop = id_valid & id_ready; rd_ptr advances. id_valid = (count != 0). id_pc/id_instr = entry[rd_ptr], registered storage with a combinational read.
- Latency: a response accepted at edge N is visible on id_* after edge N (one-cycle fill latency).
- Simultaneous push and pop: count unchanged; both pointers advance. Legal when full only if a pop occurs and push is blocked; push is never allowed at count == DEPTH.
- Full (count == DEPTH): imem_req = 0 and fetch_pc holds. The request re-asserts the cycle after any pop.
- Empty: id_valid = 0; id_ready is ignored.
- Redirect has priority over push and pop in the same cycle. At the next edge:
  - count = 0, pointers = 0;
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00} (low bits forced to zero);
  - any imem_ready in the redirect cycle is ignored (imem_req is 0).
  - An ID pop in that cycle is discarded; the ID side must treat it as flushed.
  - Cycle after redirect: imem_req = 1 with imem_addr = redirect target.
- Pointers wrap modulo DEPTH. count is a $clog2(DEPTH)+1-bit field.
- State: no explicit FSM. The {count, fetch_pc} pair defines FILLING / FULL / EMPTY; only the redirect and reset paths override it.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- When defined: if count == 0, accept occurs, and no redirect, then id_valid = 1 and id_pc/id_instr = {fetch_pc, imem_rdata} combinationally in the same cycle.
  - If id_ready is also 1, the entry is consumed and not written (count stays 0).
  - Otherwise it is pushed as normal.
  - Fill latency becomes 0 cycles.
- When undefined: always one-cycle fill latency; no combinational path from imem_* to id_*.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN default;
  - RESET_PC default;
  - PC increment constant 4;
  - typedef fetch_entry_t {pc, instr}.
- One sub-module is natural: sync_fifo (parametrised width/depth, push/pop/flush, count, full/empty). fetch_queue adds PC generation, handshakes, redirect and bypass around it.

Test Plan:
- Reset release, imem_ready=1, id_ready=0 -> addresses 0x0,0x4,0x8,0xC accepted; imem_req drops after 4 accepts; id_pc=0x0, id_valid=1 held.
- Memory stalls 3 cycles at 0x8 (imem_ready=0) -> imem_addr stays 0x8 for all 3 cycles; no push; next accept pushes pc 0x8.
- Full FIFO, id_ready=1 for one cycle -> pops pc 0x0; imem_req re-asserts the next cycle with addr 0x10; count returns to 4.
- redirect=1 with redirect_pc=0x103 while 3 entries are buffered and imem_ready=1 -> next cycle id_valid=0, count=0, imem_addr=0x100; the redirect-cycle response is never seen at id_*.
- rst pulsed low for half a cycle mid-stall -> all outputs 0 immediately; after release the first imem_addr is RESET_PC.
- FETCH_BYPASS_EN defined, empty FIFO, imem_ready=1, id_ready=1, rdata=0x00500093 -> id_valid=1, id_instr=0x00500093 the same cycle, count stays 0. Same stimulus undefined -> id_valid rises one cycle later.
